col_beat_sched: RTL and testbench
=================================

# col_beat_sched

Upstream neighbour of the column extractor in the fetch unit. Consumes the raw 128-bit row-major read stream from memory, tracks the byte position of every beat against the requested column of every row, and forwards only beats that carry column bytes. Each forwarded beat is tagged with the first byte index, the exclusive end byte index and the beat span of the column fragment, in exactly the form the extractor's enable/data/start/end/size inputs expect.

## Interface
Parameters:
- BUS_BYTES, 16, bytes per data beat
- BUS_BITS, 128, data beat width (8*BUS_BYTES)
- CFG_W, 16, width of row_size / row_count / col_offset

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_start  in  1  one-cycle pulse; samples configuration in IDLE
- i_row_size  in  CFG_W  row length in bytes, ≥32
- i_row_count  in  CFG_W  rows to process, ≥1
- i_col_offset  in  CFG_W  column byte offset within the row
- i_col_width  in  5  column width in bytes, 1..16
- i_s_valid  in  1  input beat valid
- i_s_data  in  BUS_BITS  input beat, byte 0 in bits [7:0]
- i_s_last  in  1  final beat of the read stream
- o_s_ready  out  1  high in RUN and FLUSH
- o_en  out  1  forwarded-beat valid, one cycle
- o_r_data  out  BUS_BITS  forwarded beat
- o_r_start  out  4  first column byte in beat
- o_end  out  7  exclusive end byte index, 1..16
- o_r_size  out  5  beats spanned by this row's column, 1 or 2
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle pulse on completion
- o_err  out  1  sticky config error, cleared by next accepted i_start

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: if i_start, validate config. Invalid means col_offset+col_width > row_size, col_width = 0 or > 16, row_size < 32, or row_count = 0. Invalid: set o_err, stay IDLE. Valid: clear o_err, latch config, pos=0, lo=col_offset, hi=col_offset+col_width, row_cnt=0, go RUN.
- i_start outside IDLE is ignored.
- Beat accepted when i_s_valid & o_s_ready. pos is the byte address of the accepted beat. pos, lo and hi are 32-bit unsigned.
- RUN, accepted beat:
  - Fragment present iff lo < pos+16 and hi > pos. Then o_r_start = max(lo,pos)-pos, o_end = min(hi,pos+16)-pos, o_r_size = (lo[3:0]+col_width > 16) ? 2 : 1, all evaluated with the current row's lo.
  - If hi ≤ pos+16: lo += row_size, hi += row_size, row_cnt++. If row_cnt reaches row_count, go FLUSH, or go straight to IDLE with o_done if i_s_last is on this beat.
  - pos += 16 after every accepted beat.
- row_size ≥ 32 with col_width ≤ 16 guarantees at most one fragment per beat.
- FLUSH: accept and discard beats, o_en stays low. On the accepted beat with i_s_last: pulse o_done, go IDLE.
- i_s_last in RUN before all rows complete: pulse o_done, set o_err, go IDLE.

## Timing
- Reset: state=IDLE; o_en, o_busy, o_done, o_err, o_s_ready = 0; o_r_data, o_r_start, o_end, o_r_size = 0.
- Latency: o_en and its tags are registered, 1 cycle after the accepting edge.
- o_en is low on cycles with no accepted fragment beat. There is no output backpressure; the consumer must take every o_en beat.
- o_done is asserted in the cycle after the accepting edge of the terminating beat, aligned with that beat's o_en if it carried a fragment.
- Input gaps (i_s_valid low) freeze all state.
- Reset asserted mid-RUN returns to IDLE at the next edge and drops all pending outputs.

## Structure
- Shared package rme_fetch_pkg: BUS_BYTES, BUS_BITS, BUS_BYTE_IDX_W=4, state enum {IDLE, RUN, FLUSH}, config struct.
- One sub-module, col_frag_calc (combinational): inputs pos, lo, hi, col_width; outputs hit, start, end, size, row_done. Everything else lives in col_beat_sched.

## Test plan
- row_size=32, offset=0, width=9, rows=2, 4 beats: o_en on beats 0 and 2, each start=0 end=9 size=1. o_done after beat 3 (last).
- row_size=32, offset=12, width=9, rows=1, 2 beats: beat0 start=12 end=16 size=2; beat1 start=0 end=5 size=2; o_done.
- row_size=40, offset=0, width=8, rows=3, 8 beats: fragments on beat0 (0/8), beat2 (8/16), beat5 (0/8). Beats 6–7 flushed, o_done on beat 7.
- Random i_s_valid gaps on the previous case: identical fragment sequence and tags.
- offset=30, width=4, row_size=32: o_err=1, stays IDLE. Next valid i_start clears o_err.
- Reset pulsed mid-RUN: all outputs 0 next cycle, o_busy=0. A new i_start then runs correctly from pos=0.

Source files
------------

// File: rtl/rme_fetch_pkg.sv
// Shared definitions for the row-major fetch path: bus geometry, the
// beat scheduler state encoding and the column configuration record.
package rme_fetch_pkg;

  localparam int BUS_BYTES      = 16;
  localparam int BUS_BITS       = 8 * BUS_BYTES;
  localparam int BUS_BYTE_IDX_W = 4;
  localparam int CFG_W          = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [CFG_W-1:0] row_size;
    logic [CFG_W-1:0] row_count;
    logic [CFG_W-1:0] col_offset;
    logic [4:0]       col_width;
  } cfg_t;

  // A column must fit inside its row, be 1..16 bytes wide, and rows must be
  // at least two beats long so no beat ever carries two fragments.
  function automatic logic cfg_invalid(input cfg_t c);
    logic [31:0] col_hi;
    col_hi = 32'(c.col_offset) + 32'(c.col_width);
    return (col_hi > 32'(c.row_size)) ||
           (c.col_width == 5'd0) ||
           (c.col_width > 5'd16) ||
           (c.row_size < CFG_W'(32)) ||
           (c.row_count == '0);
  endfunction

endpackage

// File: rtl/col_frag_calc.sv
// Combinational overlap of one bus beat [pos, pos+16) with the current
// row's column window [lo, hi): fragment presence, byte bounds inside the
// beat, how many beats the column spans, and whether the row ends here.
module col_frag_calc
  import rme_fetch_pkg::*;
(
  input  logic [31:0]               pos,
  input  logic [31:0]               lo,
  input  logic [31:0]               hi,
  input  logic [4:0]                col_width,
  output logic                      hit,
  output logic [BUS_BYTE_IDX_W-1:0] start,
  output logic [6:0]                frag_end,
  output logic [4:0]                size,
  output logic                      row_done
);

  logic [31:0] beat_end;
  logic [31:0] first_byte;
  logic [31:0] last_byte;
  logic [5:0]  lo_span;

  // Clip the column window to the beat window and express it beat-relative.
  always_comb begin
    beat_end   = pos + 32'(BUS_BYTES);
    first_byte = (lo > pos) ? lo : pos;
    last_byte  = (hi < beat_end) ? hi : beat_end;
    lo_span    = {2'b00, lo[3:0]} + {1'b0, col_width};
    hit        = (lo < beat_end) && (hi > pos);
    start      = BUS_BYTE_IDX_W'(first_byte - pos);
    frag_end   = 7'(last_byte - pos);
    size       = (lo_span > 6'd16) ? 5'd2 : 5'd1;
    row_done   = (hi <= beat_end);
  end

endmodule

// File: rtl/col_beat_sched.sv
// Filters the row-major read stream down to the beats that carry bytes of
// the requested column and tags each one for the column extractor.
//
// Handshake: an input beat is transferred on a rising edge where
// i_s_valid and o_s_ready are both high; o_s_ready depends only on state.
// The output side has no ready: every o_en beat must be taken.
module col_beat_sched #(
  parameter int BUS_BYTES = 16,
  parameter int BUS_BITS  = 128,
  parameter int CFG_W     = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [CFG_W-1:0]    i_row_size,
  input  logic [CFG_W-1:0]    i_row_count,
  input  logic [CFG_W-1:0]    i_col_offset,
  input  logic [4:0]          i_col_width,
  input  logic                i_s_valid,
  input  logic [BUS_BITS-1:0] i_s_data,
  input  logic                i_s_last,
  output logic                o_s_ready,
  output logic                o_en,
  output logic [BUS_BITS-1:0] o_r_data,
  output logic [3:0]          o_r_start,
  output logic [6:0]          o_end,
  output logic [4:0]          o_r_size,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  import rme_fetch_pkg::*;

  // Visible for checkers that bind to the scheduler's progress.
  state_t           state;

  logic [CFG_W-1:0] row_size_q;
  logic [CFG_W-1:0] row_count_q;
  logic [4:0]       col_width_q;
  logic [CFG_W-1:0] row_cnt;
  logic [31:0]      pos;
  logic [31:0]      lo;
  logic [31:0]      hi;

  cfg_t             cfg_in;
  logic             cfg_bad;
  logic             frag_hit;
  logic [3:0]       frag_start;
  logic [6:0]       frag_end;
  logic [4:0]       frag_size;
  logic             row_done;
  logic             last_row;

  assign cfg_in = '{row_size:   i_row_size,
                    row_count:  i_row_count,
                    col_offset: i_col_offset,
                    col_width:  i_col_width};
  assign cfg_bad  = cfg_invalid(cfg_in);
  assign last_row = ((row_cnt + CFG_W'(1)) == row_count_q);

  assign o_busy    = (state != IDLE);
  assign o_s_ready = (state == RUN) || (state == FLUSH);

  col_frag_calc u_frag (
    .pos       (pos),
    .lo        (lo),
    .hi        (hi),
    .col_width (col_width_q),
    .hit       (frag_hit),
    .start     (frag_start),
    .frag_end  (frag_end),
    .size      (frag_size),
    .row_done  (row_done)
  );

  // Scheduler FSM: configuration, row tracking and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      row_size_q  <= '0;
      row_count_q <= '0;
      col_width_q <= '0;
      row_cnt     <= '0;
      pos         <= '0;
      lo          <= '0;
      hi          <= '0;
      o_en        <= 1'b0;
      o_r_data    <= '0;
      o_r_start   <= '0;
      o_end       <= '0;
      o_r_size    <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_en   <= 1'b0;
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (cfg_bad) begin
              o_err <= 1'b1;
            end else begin
              o_err       <= 1'b0;
              row_size_q  <= i_row_size;
              row_count_q <= i_row_count;
              col_width_q <= i_col_width;
              row_cnt     <= '0;
              pos         <= '0;
              lo          <= 32'(i_col_offset);
              hi          <= 32'(i_col_offset) + 32'(i_col_width);
              state       <= RUN;
            end
          end
        end
        RUN: begin
          if (i_s_valid) begin
            if (frag_hit) begin
              o_en      <= 1'b1;
              o_r_data  <= i_s_data;
              o_r_start <= frag_start;
              o_end     <= frag_end;
              o_r_size  <= frag_size;
            end
            pos <= pos + 32'(BUS_BYTES);
            if (row_done) begin
              lo      <= lo + 32'(row_size_q);
              hi      <= hi + 32'(row_size_q);
              row_cnt <= row_cnt + CFG_W'(1);
            end
            if (row_done && last_row) begin
              if (i_s_last) begin
                o_done <= 1'b1;
                state  <= IDLE;
              end else begin
                state <= FLUSH;
              end
            end else if (i_s_last) begin
              // Stream ended before every row's column was seen.
              o_done <= 1'b1;
              o_err  <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (i_s_valid && i_s_last) begin
            o_done <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_col_beat_sched.sv
// Directed bench for col_beat_sched. A beat-level model derives, for each
// accepted beat, which row's column overlaps it and where the stream must
// end; a compare process checks every cycle against it, and per-case
// fragment logs are pinned against hand-computed tag lists.
module tb_col_beat_sched;

  localparam int BUS_BITS = 128;
  localparam int CFG_W    = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [CFG_W-1:0]    row_size = '0;
  logic [CFG_W-1:0]    row_count = '0;
  logic [CFG_W-1:0]    col_offset = '0;
  logic [4:0]          col_width = '0;
  logic                s_valid = 1'b0;
  logic [BUS_BITS-1:0] s_data = '0;
  logic                s_last = 1'b0;

  logic                s_ready;
  logic                en;
  logic [BUS_BITS-1:0] r_data;
  logic [3:0]          r_start;
  logic [6:0]          r_end;
  logic [4:0]          r_size;
  logic                busy;
  logic                done;
  logic                err;

  col_beat_sched dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_row_size   (row_size),
    .i_row_count  (row_count),
    .i_col_offset (col_offset),
    .i_col_width  (col_width),
    .i_s_valid    (s_valid),
    .i_s_data     (s_data),
    .i_s_last     (s_last),
    .o_s_ready    (s_ready),
    .o_en         (en),
    .o_r_data     (r_data),
    .o_r_start    (r_start),
    .o_end        (r_end),
    .o_r_size     (r_size),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic                en;
    logic                done;
    logic                busy;
    logic                err;
    logic                zero;
    logic [3:0]          st;
    logic [6:0]          fe;
    logic [4:0]          sz;
    logic [BUS_BITS-1:0] data;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  logic [15:0]   got_q[$];
  logic [15:0]   want_q[$];
  int            got_done = 0;
  int            total = 0;
  int            bad = 0;

  // Model state: whole-transfer view, not per-row counters.
  logic m_active = 1'b0;
  logic m_err = 1'b0;
  int   m_k, m_end_beat, m_rs, m_rows, m_off, m_w;

  task automatic check(input string name, input logic [BUS_BITS-1:0] act,
                       input logic [BUS_BITS-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] frag(input int st, input int fe, input int sz);
    return {4'(st), 7'(fe), 5'(sz)};
  endfunction

  // Compare DUT outputs against the model once per cycle, mid-cycle.
  exp_t cmp_e;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      cmp_e = exp_t'(exp_q.pop_front());
      check("en", BUS_BITS'(en), BUS_BITS'(cmp_e.en));
      check("done", BUS_BITS'(done), BUS_BITS'(cmp_e.done));
      check("busy", BUS_BITS'(busy), BUS_BITS'(cmp_e.busy));
      check("ready", BUS_BITS'(s_ready), BUS_BITS'(cmp_e.busy));
      check("err", BUS_BITS'(err), BUS_BITS'(cmp_e.err));
      if (cmp_e.en) begin
        check("start", BUS_BITS'(r_start), BUS_BITS'(cmp_e.st));
        check("end", BUS_BITS'(r_end), BUS_BITS'(cmp_e.fe));
        check("size", BUS_BITS'(r_size), BUS_BITS'(cmp_e.sz));
        check("data", r_data, cmp_e.data);
      end
      if (cmp_e.zero) begin
        check("rst_tags", BUS_BITS'({r_start, r_end, r_size}), '0);
        check("rst_data", r_data, '0);
      end
    end
    if (en) got_q.push_back({r_start, r_end, r_size});
    if (done) got_done++;
  end

  // ---------------- driver ----------------
  task automatic set_cfg(input int rs, input int rows, input int off, input int w);
    row_size   = CFG_W'(rs);
    row_count  = CFG_W'(rows);
    col_offset = CFG_W'(off);
    col_width  = 5'(w);
  endtask

  // Drive one cycle of inputs, advance the model, queue what must appear.
  task automatic step(input logic r, input logic s, input logic v, input logic l);
    exp_t e;
    logic [BUS_BITS-1:0] d;
    int pos, lo, hi, first, lastb;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    rst_n = r; start = s; s_valid = v; s_last = l; s_data = d;
    e = '0;
    if (!r) begin
      m_active = 1'b0;
      m_err = 1'b0;
      e.zero = 1'b1;
    end else if (!m_active) begin
      if (s) begin
        if ((int'(col_offset) + int'(col_width) > int'(row_size)) || col_width == 0 ||
            col_width > 16 || row_size < 32 || row_count == 0) begin
          m_err = 1'b1;
        end else begin
          m_err = 1'b0;
          m_active = 1'b1;
          m_k = 0;
          m_rs = int'(row_size); m_rows = int'(row_count);
          m_off = int'(col_offset); m_w = int'(col_width);
          m_end_beat = (m_off + (m_rows - 1) * m_rs + m_w - 1) / 16;
        end
      end
    end else if (v) begin
      pos = 16 * m_k;
      for (int rr = 0; rr < m_rows; rr++) begin
        lo = m_off + rr * m_rs;
        hi = lo + m_w;
        if (lo < pos + 16 && hi > pos) begin
          first = (lo > pos) ? lo : pos;
          lastb = (hi < pos + 16) ? hi : pos + 16;
          e.en = 1'b1;
          e.st = 4'(first - pos);
          e.fe = 7'(lastb - pos);
          e.sz = ((lo % 16) + m_w > 16) ? 5'd2 : 5'd1;
          e.data = d;
        end
      end
      if (l) begin
        e.done = 1'b1;
        if (m_k < m_end_beat) m_err = 1'b1;
        m_active = 1'b0;
      end
      m_k++;
    end
    e.busy = m_active;
    e.err = m_err;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_stream(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      step(1'b1, 1'b0, 1'b1, 1'(k == n - 1));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_logs();
    got_q.delete();
    want_q.delete();
    got_done = 0;
  endtask

  task automatic check_log(input string name, input int dones);
    check({name, "_frag_count"}, BUS_BITS'(got_q.size()), BUS_BITS'(want_q.size()));
    for (int i = 0; i < got_q.size() && i < want_q.size(); i++)
      check({name, "_frag"}, BUS_BITS'(got_q[i]), BUS_BITS'(want_q[i]));
    check({name, "_done_count"}, BUS_BITS'(got_done), BUS_BITS'(dones));
    clear_logs();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("reset_busy", BUS_BITS'(busy), '0);
    clear_logs();

    // Two rows, column at row start, one fragment per row.
    set_cfg(32, 2, 0, 9);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_stream(4, 1'b0);
    want_q = '{frag(0, 9, 1), frag(0, 9, 1)};
    check_log("case1", 1);

    // Column straddling a beat boundary.
    set_cfg(32, 1, 12, 9);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_stream(2, 1'b0);
    want_q = '{frag(12, 16, 2), frag(0, 5, 2)};
    check_log("case2", 1);

    // Rows not beat aligned, trailing beats flushed.
    set_cfg(40, 3, 0, 8);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_stream(8, 1'b0);
    want_q = '{frag(0, 8, 1), frag(8, 16, 1), frag(0, 8, 1)};
    check_log("case3", 1);

    // Same with valid gaps and stray start pulses while busy.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_stream(8, 1'b1);
    want_q = '{frag(0, 8, 1), frag(8, 16, 1), frag(0, 8, 1)};
    check_log("case3_gaps", 1);

    // Column overruns row: error, stays idle.
    set_cfg(32, 1, 30, 4);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("cfg_err_set", BUS_BITS'(err), BUS_BITS'(1));
    check("cfg_err_idle", BUS_BITS'(busy), '0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(32, 1, 0, 16);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("cfg_err_clear", BUS_BITS'(err), '0);
    run_stream(2, 1'b0);
    want_q = '{frag(0, 0, 1)};
    want_q[0] = frag(0, 16, 1);
    check_log("full_width", 1);

    // Stream ends before the second row is reached.
    set_cfg(32, 2, 0, 9);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_stream(2, 1'b0);
    check("early_last_err", BUS_BITS'(err), BUS_BITS'(1));
    want_q = '{frag(0, 9, 1)};
    check_log("early_last", 1);

    // Reset in the middle of a run, then a clean restart.
    set_cfg(40, 3, 0, 8);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("midrst_busy", BUS_BITS'(busy), '0);
    check("midrst_en", BUS_BITS'(en), '0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    clear_logs();
    set_cfg(32, 2, 0, 9);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_stream(4, 1'b0);
    want_q = '{frag(0, 9, 1), frag(0, 9, 1)};
    check_log("after_rst", 1);

    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
